// File: rtl/raster_dispatch.sv
// raster_dispatch: collects three vertices from one of two round-robin
// ports and hands the finished triangle to the rasterizer.
module raster_dispatch #(
    parameter int VERTEX_TYPE_SIZE = 96,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s0_valid,
    output logic                        s0_ready,
    input  logic [VERTEX_TYPE_SIZE-1:0] s0_vertex,
    input  logic                        s1_valid,
    output logic                        s1_ready,
    input  logic [VERTEX_TYPE_SIZE-1:0] s1_vertex,
    input  logic                        flush,
    output logic                        raster_start,
    input  logic                        raster_done,
    output logic [VERTEX_TYPE_SIZE-1:0] tri_v1,
    output logic [VERTEX_TYPE_SIZE-1:0] tri_v2,
    output logic [VERTEX_TYPE_SIZE-1:0] tri_v3,
    output logic                        grant_port,
    output logic                        busy,
    output logic [CNT_W-1:0]            tri_count
);

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                        rr_ptr;
    logic                        grant_nx;
    logic                        done_q;
    logic                        done_rise;
    logic                        gnt_valid;
    logic                        accept;
    logic [1:0]                  slot;
    logic [VERTEX_TYPE_SIZE-1:0] in_vertex;

    assign done_rise = raster_done & ~done_q;
    assign gnt_valid = grant_port ? s1_valid : s0_valid;
    assign in_vertex = grant_port ? s1_vertex : s0_vertex;
    // Accept never looks at ready, so ready stays free of valid.
    assign accept    = (state == GATHER) & ~flush & gnt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant_port;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        raster_start = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (s0_valid | s1_valid) begin
                    grant_nx = (s0_valid & s1_valid) ? rr_ptr : s1_valid;
                    state_nx = GATHER;
                end
            end
            GATHER: begin
                if (flush) begin
                    state_nx = IDLE;
                end else begin
                    s0_ready = ~grant_port;
                    s1_ready = grant_port;
                    if (accept && slot == 2'd2) begin
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                raster_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_port <= 1'b0;
            rr_ptr     <= 1'b0;
            done_q     <= 1'b0;
            slot       <= 2'd0;
            tri_count  <= '0;
            tri_v1     <= '0;
            tri_v2     <= '0;
            tri_v3     <= '0;
        end else begin
            done_q     <= raster_done;
            grant_port <= grant_nx;
            if (state == IDLE) begin
                slot <= 2'd0;
            end
            if (accept) begin
                case (slot)
                    2'd0:    tri_v1 <= in_vertex;
                    2'd1:    tri_v2 <= in_vertex;
                    default: tri_v3 <= in_vertex;
                endcase
                slot <= slot + 2'd1;
            end
            if (state == WAIT && done_rise) begin
                tri_count <= tri_count + 1'b1;
                rr_ptr    <= ~rr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_raster_dispatch.sv
// tb_raster_dispatch: directed and random stimulus checked against a
// transaction-level scoreboard of accepted vertices and completions.
module tb_raster_dispatch;

    localparam int VW = 96;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          s0_valid;
    logic          s0_ready;
    logic [VW-1:0] s0_vertex;
    logic          s1_valid;
    logic          s1_ready;
    logic [VW-1:0] s1_vertex;
    logic          flush;
    logic          raster_start;
    logic          raster_done;
    logic [VW-1:0] tri_v1;
    logic [VW-1:0] tri_v2;
    logic [VW-1:0] tri_v3;
    logic          grant_port;
    logic          busy;
    logic [CW-1:0] tri_count;

    raster_dispatch #(
        .VERTEX_TYPE_SIZE(VW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s0_valid(s0_valid),
        .s0_ready(s0_ready),
        .s0_vertex(s0_vertex),
        .s1_valid(s1_valid),
        .s1_ready(s1_ready),
        .s1_vertex(s1_vertex),
        .flush(flush),
        .raster_start(raster_start),
        .raster_done(raster_done),
        .tri_v1(tri_v1),
        .tri_v2(tri_v2),
        .tri_v3(tri_v3),
        .grant_port(grant_port),
        .busy(busy),
        .tri_count(tri_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // scoreboard state
    logic [VW-1:0] q[$];
    logic [VW-1:0] last_tri[3];
    int            qport;
    bit            pending;
    bit            prev_done;
    logic [CW-1:0] mcnt;
    int            ncomp;
    int            glog[$];

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        q.delete();
        pending   = 0;
        prev_done = 0;
        mcnt      = '0;
        ncomp     = 0;
    endtask

    function automatic logic [VW-1:0] rv();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic take(input int p, input logic [VW-1:0] v);
        if (q.size() == 0) qport = p;
        else chk("same_port", p, qport);
        chk("grant_match", grant_port, p);
        q.push_back(v);
    endtask

    task automatic monitor();
        if (!rst_n) return;
        if (s0_ready && s1_ready) chk("both_ready", 1, 0);
        if (flush && (s0_ready || s1_ready)) chk("flush_ready", 1, 0);
        chk("count", tri_count, mcnt);
        if (pending) begin
            chk("wait_busy", busy, 1);
            chk("hold_v1", tri_v1, last_tri[0]);
            chk("hold_v2", tri_v2, last_tri[1]);
            chk("hold_v3", tri_v3, last_tri[2]);
            if (raster_done && !prev_done) begin
                mcnt++;
                ncomp++;
                pending = 0;
            end
        end
        if (flush && (q.size() == 1 || q.size() == 2)) q.delete();
        if (s0_valid && s0_ready) take(0, s0_vertex);
        if (s1_valid && s1_ready) take(1, s1_vertex);
        if (raster_start) begin
            chk("start_busy", busy, 1);
            chk("start_nverts", q.size(), 3);
            if (q.size() == 3) begin
                chk("start_v1", tri_v1, q[0]);
                chk("start_v2", tri_v2, q[1]);
                chk("start_v3", tri_v3, q[2]);
                chk("start_grant", grant_port, qport);
                last_tri[0] = q[0];
                last_tri[1] = q[1];
                last_tri[2] = q[2];
            end
            glog.push_back(int'(grant_port));
            q.delete();
            pending = 1;
        end
        prev_done = raster_done;
    endtask

    task automatic smp();
        @(negedge clk);
        monitor();
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s0_valid    = 1'b0;
        s1_valid    = 1'b0;
        flush       = 1'b0;
        raster_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        mreset();
        smp();
        nx();
        smp();
        nx();
        rst_n = 1'b1;
    endtask

    task automatic push(input int p, input logic [VW-1:0] v, output int w);
        bit acc;
        acc = 0;
        w   = 0;
        if (p == 1) begin
            s1_valid  = 1'b1;
            s1_vertex = v;
        end else begin
            s0_valid  = 1'b1;
            s0_vertex = v;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            smp();
            acc = (p == 1) ? s1_ready : s0_ready;
            nx();
            if (!acc) w++;
        end
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic pulse_done();
        raster_done = 1'b0;
        smp();
        nx();
        raster_done = 1'b1;
        smp();
        nx();
        raster_done = 1'b0;
    endtask

    task automatic run(input int maxc, input int target, input int pv0,
                       input int pv1, input int pf, input bit rnd_done);
        int dcnt;
        bit hit;
        dcnt = 0;
        hit  = 0;
        for (int i = 0; i < maxc && !hit; i++) begin
            smp();
            if (raster_start) dcnt = 2;
            if (target >= 0 && ncomp >= target) hit = 1;
            nx();
            if (hit) begin
                idle_in();
            end else begin
                s0_valid  = ($urandom_range(99) < pv0);
                s1_valid  = ($urandom_range(99) < pv1);
                s0_vertex = rv();
                s1_vertex = rv();
                flush     = ($urandom_range(99) < pf);
                if (rnd_done) begin
                    raster_done = ($urandom_range(3) == 0);
                end else begin
                    raster_done = (dcnt == 1);
                    if (dcnt > 0) dcnt--;
                end
            end
        end
        idle_in();
        if (target >= 0) chk("run_target", hit, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] va, vb, vc, vx;
        int w;
        rst_n     = 1'b0;
        s0_vertex = '0;
        s1_vertex = '0;
        idle_in();
        mreset();
        #3;
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_start", raster_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_port, 0);
        chk("rst_count", tri_count, 0);
        chk("rst_v1", tri_v1, 0);
        chk("rst_v2", tri_v2, 0);
        chk("rst_v3", tri_v3, 0);
        do_reset();

        // back-to-back triangle from port 0, minimum latency
        va = rv(); vb = rv(); vc = rv();
        push(0, va, w); chk("lat_a", w, 1);
        push(0, vb, w); chk("lat_b", w, 0);
        push(0, vc, w); chk("lat_c", w, 0);
        smp();
        chk("b2b_start", raster_start, 1);
        chk("b2b_v1", tri_v1, va);
        chk("b2b_v2", tri_v2, vb);
        chk("b2b_v3", tri_v3, vc);
        chk("b2b_grant", grant_port, 0);
        nx();
        pulse_done();
        smp();
        chk("b2b_count", tri_count, 1);
        chk("b2b_idle", busy, 0);
        nx();

        // stall for five cycles between second and third vertex
        va = rv(); vb = rv(); vc = rv();
        push(0, va, w);
        push(0, vb, w);
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("stall_nostart", raster_start, 0);
            chk("stall_busy", busy, 1);
            nx();
        end
        push(0, vc, w);
        smp();
        chk("stall_start", raster_start, 1);
        chk("stall_v1", tri_v1, va);
        chk("stall_v2", tri_v2, vb);
        chk("stall_v3", tri_v3, vc);
        nx();
        pulse_done();
        smp();
        chk("stall_count", tri_count, 2);
        nx();

        // flush after two vertices, vertex in flush cycle refused
        va = rv(); vb = rv(); vx = rv();
        push(0, va, w);
        push(0, vb, w);
        s0_valid  = 1'b1;
        s0_vertex = vx;
        flush     = 1'b1;
        smp();
        chk("flush_refuse", s0_ready, 0);
        nx();
        idle_in();
        smp();
        chk("flush_idle", busy, 0);
        chk("flush_nostart", raster_start, 0);
        chk("flush_count", tri_count, 2);
        nx();
        va = rv(); vb = rv(); vc = rv();
        push(0, va, w);
        push(0, vb, w);
        push(0, vc, w);
        smp();
        chk("refill_start", raster_start, 1);
        chk("refill_v1", tri_v1, va);
        chk("refill_v3", tri_v3, vc);
        nx();
        pulse_done();
        smp();
        chk("refill_count", tri_count, 3);
        nx();

        // done already high when entering WAIT does not complete
        raster_done = 1'b1;
        push(0, rv(), w);
        push(0, rv(), w);
        push(0, rv(), w);
        smp();
        chk("held_start", raster_start, 1);
        nx();
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("held_busy", busy, 1);
            chk("held_count", tri_count, 3);
            nx();
        end
        pulse_done();
        smp();
        chk("held_done_count", tri_count, 4);
        chk("held_done_idle", busy, 0);
        nx();

        // both ports always valid: round-robin grants per triangle
        do_reset();
        glog.delete();
        run(200, 4, 100, 100, 0, 0);
        chk("rr_ntri", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("rr_grant", glog[i], i % 2);
        end

        // counter wrap at 2^CNT_W
        do_reset();
        run(600, 16, 100, 0, 0, 0);
        smp();
        chk("wrap_count", tri_count, 0);
        nx();

        // random traffic with flushes and noisy done
        do_reset();
        run(3000, -1, 60, 60, 5, 1);

        // reset while waiting on the rasterizer
        do_reset();
        push(1, rv(), w);
        push(1, rv(), w);
        push(1, rv(), w);
        smp();
        chk("rw_start", raster_start, 1);
        chk("rw_grant", grant_port, 1);
        nx();
        smp();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_s0_ready", s0_ready, 0);
        chk("rw_s1_ready", s1_ready, 0);
        chk("rw_start0", raster_start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_grant0", grant_port, 0);
        chk("rw_count", tri_count, 0);
        chk("rw_v1", tri_v1, 0);
        chk("rw_v2", tri_v2, 0);
        chk("rw_v3", tri_v3, 0);
        mreset();
        nx();
        smp();
        nx();
        rst_n = 1'b1;
        pulse_done();
        smp();
        chk("rw_late_done", tri_count, 0);
        chk("rw_late_idle", busy, 0);
        nx();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
